// File: rtl/rv_gnrl_pipe_slice.sv
// ---------------------------------------------------------------------------
// rv_gnrl_pipe_slice
//
// Purpose:
//   Parametrised multi-stage pipeline register with a valid/ready handshake,
//   a synchronous flush back to DEF_VAL and an occupancy count. It sits
//   between core pipeline stages (IF/ID, ID/EX, LSU request path) wherever a
//   registered, stallable transfer is needed. Entries leave in strict FIFO
//   order.
//
// Parameters:
//   DW       payload width in bits
//   STAGES   number of register stages (must be >= 1)
//   DEF_VAL  value held by every data register after reset or flush
//   CW       width of the occupancy count, $clog2(2*STAGES+1)
//
// Ports:
//   clk      clock; every flop updates on the rising edge
//   rst      asynchronous reset, active-high
//   flush    synchronous flush; discards every held entry
//   i_valid  upstream payload valid
//   i_ready  slice can accept i_data this cycle
//   i_data   upstream payload
//   o_valid  last stage holds a valid payload
//   o_ready  downstream accepts o_data this cycle
//   o_data   last-stage payload; DEF_VAL while o_valid is low
//   cnt      number of valid entries held in the slice
//
// Build option:
//   RV_GNRL_PIPE_SKID_EN
//     Defined: each stage gets a second (skid) register. Stage ready then
//     comes straight from a flop, so there is no combinational path from
//     o_ready to i_ready. Capacity grows to 2*STAGES.
//     Undefined: plain combinational ready chain, capacity STAGES.
// ---------------------------------------------------------------------------
module rv_gnrl_pipe_slice #(
  parameter int              DW      = 32,
  parameter int              STAGES  = 2,
  parameter logic [DW-1:0]   DEF_VAL = '0,
  localparam int             CW      = $clog2(2*STAGES+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] cnt
);

  generate
    if (STAGES < 1) begin : g_stages_chk
      $error("rv_gnrl_pipe_slice: STAGES must be >= 1");
    end
  endgenerate

  // Main register of every stage; index 0 is the input side.
  logic [STAGES-1:0] v;
  logic [DW-1:0]     d [STAGES];

  // rdy[k] is the ready seen by stage k-1 (or by upstream for k=0);
  // rdy[STAGES] is the downstream ready.
  logic [STAGES:0]   rdy;

  // Valid/data offered to each stage by its upstream neighbour.
  logic [STAGES-1:0] vin;
  logic [DW-1:0]     din [STAGES];

  logic up_fire;
  logic dn_fire;

  // Reset and flush both hold off the upstream side, so nothing new enters
  // while the slice is being cleared.
  assign i_ready = rdy[0] & ~rst & ~flush;
  assign o_valid = v[STAGES-1];
  assign o_data  = v[STAGES-1] ? d[STAGES-1] : DEF_VAL;

  assign up_fire = i_valid & i_ready;
  assign dn_fire = o_valid & o_ready;

  // Stage k is fed from stage k-1; stage 0 only sees a beat once the
  // upstream handshake actually happens.
  always_comb begin
    vin[0] = up_fire;
    din[0] = i_data;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v[k-1];
      din[k] = d[k-1];
    end
  end

`ifdef RV_GNRL_PIPE_SKID_EN

  // Skid register of every stage; it only ever holds the younger of the
  // two beats in a stage, the main register always holds the older one.
  logic [STAGES-1:0] sv;
  logic [DW-1:0]     sd [STAGES];

  // A stage is ready as long as its skid slot is free, which is purely a
  // flop output; this is what breaks the long combinational ready chain.
  always_comb begin
    rdy[STAGES] = o_ready;
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = ~sv[k];
    end
  end

  // A beat that arrives while the main register is stuck lands in the skid
  // register; the skid entry moves into the main register as soon as the
  // old one drains, and no new beat is taken until that has happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v  <= '0;
      sv <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k]  <= DEF_VAL;
        sd[k] <= DEF_VAL;
      end
    end else if (flush) begin
      v  <= '0;
      sv <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k]  <= DEF_VAL;
        sd[k] <= DEF_VAL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (sv[k]) begin
          if (rdy[k+1]) begin
            d[k]  <= sd[k];
            sv[k] <= 1'b0;
          end
        end else if (vin[k]) begin
          if (!v[k] || rdy[k+1]) begin
            v[k] <= 1'b1;
            d[k] <= din[k];
          end else begin
            sv[k] <= 1'b1;
            sd[k] <= din[k];
          end
        end else if (rdy[k+1]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

`else

  // Combinational backward ready chain: a stage can take a beat when it is
  // empty or when its own content moves on in the same cycle.
  always_comb begin
    logic r;
    r           = o_ready;
    rdy[STAGES] = o_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
  end

  // A stage that drains without refilling only drops its valid bit; the
  // stale data is harmless because o_data is masked while o_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= DEF_VAL;
      end
    end else if (flush) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= DEF_VAL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (vin[k] && rdy[k]) begin
          v[k] <= 1'b1;
          d[k] <= din[k];
        end else if (rdy[k+1]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

`endif

  // Occupancy tracks handshakes rather than re-counting valid bits; an
  // in and an out in the same cycle cancel, and flush always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({up_fire, dn_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_gnrl_pipe_slice.sv
// ---------------------------------------------------------------------------
// tb_rv_gnrl_pipe_slice
//
// Purpose:
//   Self-checking bench for rv_gnrl_pipe_slice (STAGES=2, DW=32, non-zero
//   DEF_VAL). The reference is a FIFO of accepted beats, each tagged with
//   its acceptance cycle: the head is visible on the output once it has had
//   STAGES cycles to travel, and no earlier than the cycle after its
//   predecessor left.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_rv_gnrl_pipe_slice;

  localparam int            DW     = 32;
  localparam int            STAGES = 2;
  localparam int            CW     = $clog2(2*STAGES+1);
  localparam logic [DW-1:0] DEF    = 32'hDEAD_BEEF;
`ifdef RV_GNRL_PIPE_SKID_EN
  localparam int            CAP    = 2*STAGES;
`else
  localparam int            CAP    = STAGES;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          flush   = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready = 1'b0;
  logic [DW-1:0] i_data  = '0;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] cnt;

  rv_gnrl_pipe_slice #(
    .DW      (DW),
    .STAGES  (STAGES),
    .DEF_VAL (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  // Free-running cycle index, stable between rising edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } entry_t;

  entry_t q[$];
  int     last_dep = -1000;

  logic          exp_i_ready;
  logic          exp_o_valid;
  logic [DW-1:0] exp_o_data;
  logic [CW-1:0] exp_cnt;

  int tests = 0;
  int fails = 0;

  function automatic void model_clear();
    q.delete();
    last_dep = -1000;
  endfunction

  // Expected outputs for the current cycle from the FIFO model.
  function automatic void predict();
    int vis;
    exp_cnt     = CW'(q.size());
    exp_i_ready = !rst && !flush && !(q.size() == CAP && !o_ready);
    exp_o_valid = 1'b0;
    if (!rst && q.size() > 0) begin
      vis = q[0].acc + STAGES;
      if (last_dep + 1 > vis) vis = last_dep + 1;
      exp_o_valid = (cyc >= vis);
    end
`ifdef RV_GNRL_PIPE_SKID_EN
    exp_i_ready = !rst && !flush && (q.size() < CAP) && i_ready;
    exp_o_valid = !rst && (q.size() > 0) && o_valid;
`endif
    exp_o_data = exp_o_valid ? q[0].data : DEF;
  endfunction

  function automatic string state_str();
    return $sformatf("got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                     i_ready, o_valid, o_data, cnt,
                     exp_i_ready, exp_o_valid, exp_o_data, exp_cnt);
  endfunction

  task automatic step_begin(input logic iv, input logic [DW-1:0] id,
                            input logic ordy, input logic fl);
    @(negedge clk);
    i_valid = iv;
    i_data  = id;
    o_ready = ordy;
    flush   = fl;
    #2;
    predict();
  endtask

  // Commit the handshakes the model expects for this cycle.
  task automatic step_end();
    logic   up;
    logic   dn;
    entry_t e;
    up = i_valid && exp_i_ready;
    dn = exp_o_valid && o_ready;
    if (flush) begin
      model_clear();
    end else begin
      if (dn) begin
        q.delete(0);
        last_dep = cyc;
      end
      if (up) begin
        e.data = i_data;
        e.acc  = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    tests++;
    if ({i_ready, o_valid, o_data, cnt} !== {1'b0, 1'b0, DEF, {CW{1'b0}}}) begin
      fails++;
      $display("[TB] FAIL reset_hold: got rdy=%b vld=%b data=%h cnt=%0d, want 0 0 %h 0",
               i_ready, o_valid, o_data, cnt, DEF);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #2;
    predict();
    tests++;
    if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
      fails++;
      $display("[TB] FAIL reset_release cyc=%0d %s", cyc, state_str());
    end
    step_end();
    for (int i = 0; i < 3; i++) begin
      step_begin(i < 2, DW'($urandom), 1'b0, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL reset_fill cyc=%0d %s", cyc, state_str());
      end
      if (i < 2) step_end();
    end
    // Assert reset in the middle of the cycle with two beats held.
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({i_ready, o_valid, o_data, cnt} !== {1'b0, 1'b0, DEF, {CW{1'b0}}}) begin
      fails++;
      $display("[TB] FAIL reset_async: got rdy=%b vld=%b data=%h cnt=%0d, want 0 0 %h 0",
               i_ready, o_valid, o_data, cnt, DEF);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #2;
    predict();
    tests++;
    if (i_ready !== 1'b1 || {o_valid, o_data, cnt} !== {exp_o_valid, exp_o_data, exp_cnt}) begin
      fails++;
      $display("[TB] FAIL reset_restart cyc=%0d %s", cyc, state_str());
    end
    step_end();
  endtask

  task automatic test_stream();
    logic [DW-1:0] got[$];
    int first_in  = -1;
    int first_out = -1;
    int last_out  = -1;
    for (int i = 0; i < 16; i++) begin
      step_begin(i < 8, DW'(i + 1), 1'b1, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL stream cyc=%0d %s", cyc, state_str());
      end
      if (i == 0) first_in = cyc;
      if (o_valid === 1'b1) begin
        got.push_back(o_data);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      step_end();
    end
    tests++;
    if (first_out - first_in !== STAGES) begin
      fails++;
      $display("[TB] FAIL stream_latency: got %0d cycles, want %0d", first_out - first_in, STAGES);
    end
    tests++;
    if (got.size() !== 8 || last_out - first_out !== 7) begin
      fails++;
      $display("[TB] FAIL stream_gapless: got %0d beats over %0d cycles, want 8 over 7",
               got.size(), last_out - first_out);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== DW'(i + 1)) begin
        fails++;
        $display("[TB] FAIL stream_order[%0d]: got %h, want %h", i, got[i], DW'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] dat;
    step_begin(1'b1, DW'(32'h11), 1'b1, 1'b0);
    tests++;
    if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
      fails++;
      $display("[TB] FAIL bp_first cyc=%0d %s", cyc, state_str());
    end
    step_end();
    dat = DW'($urandom);
    for (int i = 0; i < CAP + 4; i++) begin
      step_begin(1'b1, dat, 1'b0, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL bp_fill cyc=%0d %s", cyc, state_str());
      end
      if (exp_i_ready) dat = DW'($urandom);
      step_end();
    end
    step_begin(1'b1, dat, 1'b0, 1'b0);
    tests++;
    if ({i_ready, o_data, cnt} !== {1'b0, DW'(32'h11), CW'(CAP)}) begin
      fails++;
      $display("[TB] FAIL bp_full: got rdy=%b data=%h cnt=%0d, want rdy=0 data=00000011 cnt=%0d",
               i_ready, o_data, cnt, CAP);
    end
    step_end();
    for (int i = 0; i < CAP + 4; i++) begin
      step_begin(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL bp_release cyc=%0d %s", cyc, state_str());
      end
      step_end();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      step_begin(1'b1, DW'($urandom), 1'b0, 1'b0);
      step_end();
    end
    step_begin(1'b1, DW'(32'hAA), 1'b0, 1'b1);
    tests++;
    if (i_ready !== 1'b0 || {o_valid, o_data, cnt} !== {exp_o_valid, exp_o_data, exp_cnt}) begin
      fails++;
      $display("[TB] FAIL flush_cycle cyc=%0d %s", cyc, state_str());
    end
    step_end();
    for (int i = 0; i < 4; i++) begin
      step_begin(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL flush_after cyc=%0d %s", cyc, state_str());
      end
      tests++;
      if (o_valid === 1'b1 && o_data === DW'(32'hAA)) begin
        fails++;
        $display("[TB] FAIL flush_drop cyc=%0d: got data=%h vld=1, want dropped beat absent", cyc, o_data);
      end
      step_end();
    end
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    while (q.size() < CAP - 1 && guard < 20) begin
      step_begin(1'b1, DW'($urandom), 1'b0, 1'b0);
      step_end();
      guard++;
    end
    for (int i = 0; i < STAGES; i++) begin
      step_begin(1'b0, '0, 1'b0, 1'b0);
      step_end();
    end
    step_begin(1'b1, DW'(32'h55), 1'b1, 1'b0);
    tests++;
    if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
      fails++;
      $display("[TB] FAIL simul_cycle cyc=%0d %s", cyc, state_str());
    end
    step_end();
    step_begin(1'b0, '0, 1'b0, 1'b0);
    tests++;
    if (cnt !== CW'(CAP - 1) || {i_ready, o_valid, o_data} !== {exp_i_ready, exp_o_valid, exp_o_data}) begin
      fails++;
      $display("[TB] FAIL simul_after cyc=%0d want cnt=%0d %s", cyc, CAP - 1, state_str());
    end
    step_end();
    for (int i = 0; i < CAP + 3; i++) begin
      step_begin(1'b0, '0, 1'b1, 1'b0);
      step_end();
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dat = '0;
    logic          pend = 1'b0;
    logic          iv;
    logic          ordy;
    logic          fl;
    logic          r0;
    for (int n = 0; n < 400; n++) begin
      iv = pend ? 1'b1 : ($urandom_range(3) != 0);
      if (!pend) dat = DW'($urandom);
`ifdef RV_GNRL_PIPE_SKID_EN
      ordy = n[0];
`else
      ordy = ($urandom_range(2) != 0);
`endif
      fl = ($urandom_range(39) == 0);
      step_begin(iv, dat, ordy, fl);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL random cyc=%0d %s", cyc, state_str());
      end
`ifdef RV_GNRL_PIPE_SKID_EN
      r0 = i_ready;
      o_ready = ~o_ready;
      #1;
      tests++;
      if (i_ready !== r0) begin
        fails++;
        $display("[TB] FAIL skid_ready_indep cyc=%0d: got %b, want %b", cyc, i_ready, r0);
      end
      o_ready = ~o_ready;
      #1;
`else
      r0 = 1'b0;
`endif
      pend = iv && !exp_i_ready && !fl;
      step_end();
    end
    for (int i = 0; i < CAP + 4; i++) begin
      step_begin(1'b0, '0, 1'b1, 1'b0);
      tests++;
      if ({i_ready, o_valid, o_data, cnt} !== {exp_i_ready, exp_o_valid, exp_o_data, exp_cnt}) begin
        fails++;
        $display("[TB] FAIL random_drain cyc=%0d %s", cyc, state_str());
      end
      step_end();
    end
    tests++;
    if (cnt !== '0) begin
      fails++;
      $display("[TB] FAIL random_empty: got cnt=%0d, want 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
